// File: rtl/cim_pkg.sv
// -----------------------------------------------------------------------------
// cim_pkg
// Shared definitions for the CIM column reduction stage: the accumulator state
// enum, default datapath widths and the adder-tree depth helper.
// -----------------------------------------------------------------------------
package cim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_e;

  localparam int PROD_WIDTH_DEF = 16;
  localparam int ACC_WIDTH_DEF  = 32;

  // Number of registered reduction levels for a column of num_rows cells.
  function automatic int tree_depth(input int num_rows);
    return $clog2(num_rows);
  endfunction

endpackage

// File: rtl/cim_column_accum_if.sv
// -----------------------------------------------------------------------------
// cim_column_accum_if
// Data bus of the column accumulator: the column's products/valids coming in
// from the cell array and the valid/ready result port going to the next stage.
//   in_data   : NUM_ROWS*PROD_WIDTH products, lane i at [i*PROD_WIDTH +: PROD_WIDTH]
//   in_valid  : per-lane valid
//   out_data  : final partial sum
//   out_valid : result available
//   out_ready : consumer accepts the result
// master = producer/consumer side, slave = accumulator side.
// -----------------------------------------------------------------------------
interface cim_column_accum_if
  import cim_pkg::*;
#(
  parameter int NUM_ROWS   = 8,
  parameter int PROD_WIDTH = PROD_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) ();

  logic [NUM_ROWS*PROD_WIDTH-1:0] in_data;
  logic [NUM_ROWS-1:0]            in_valid;
  logic [ACC_WIDTH-1:0]           out_data;
  logic                           out_valid;
  logic                           out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid
  );

endinterface

// File: rtl/cim_adder_tree.sv
// -----------------------------------------------------------------------------
// cim_adder_tree
// Masks invalid lanes to zero and reduces NUM_ROWS products through
// L = log2(NUM_ROWS) registered levels of unsigned adders. A valid bit (OR of
// the lane valids) travels alongside, so sum_valid lines up with sum_data.
//   clk, rst_n   : clock, asynchronous active-high reset (name kept for
//                  consistency with the rest of the codebase)
//   in_data      : lane products, lane i at [i*PROD_WIDTH +: PROD_WIDTH]
//   in_valid     : per-lane valid
//   sum_data     : tree sum, PROD_WIDTH+L bits
//   sum_valid    : sum_data is a real vector sum
// -----------------------------------------------------------------------------
module cim_adder_tree
  import cim_pkg::*;
#(
  parameter int  NUM_ROWS   = 8,
  parameter int  PROD_WIDTH = PROD_WIDTH_DEF,
  localparam int L          = tree_depth(NUM_ROWS),
  localparam int SUM_W      = PROD_WIDTH + L
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_ROWS*PROD_WIDTH-1:0] in_data,
  input  logic [NUM_ROWS-1:0]            in_valid,
  output logic [SUM_W-1:0]               sum_data,
  output logic                           sum_valid
);

  // Heap-ordered tree: node i has children 2i and 2i+1. Indices NUM_ROWS..
  // 2*NUM_ROWS-1 are the masked lanes (combinational), 1..NUM_ROWS-1 are the
  // registered adder outputs, node 1 being the root. All nodes share the full
  // sum width; the upper bits of the shallow levels are constant zero.
  logic [SUM_W-1:0] node   [1:2*NUM_ROWS-1];
  logic [SUM_W-1:0] node_d [1:NUM_ROWS-1];
  logic [SUM_W-1:0] node_q [1:NUM_ROWS-1];
  logic [L-1:0]     vld_d;
  logic [L-1:0]     vld_q;

  always_comb begin
    for (int i = 1; i < NUM_ROWS; i++) node[i] = node_q[i];
    for (int i = 0; i < NUM_ROWS; i++)
      node[NUM_ROWS+i] = in_valid[i] ? SUM_W'(in_data[i*PROD_WIDTH +: PROD_WIDTH]) : '0;
  end

  always_comb begin
    for (int i = 1; i < NUM_ROWS; i++) node_d[i] = node[2*i] + node[2*i+1];
    vld_d[0] = |in_valid;
    for (int i = 1; i < L; i++) vld_d[i] = vld_q[i-1];
  end

  // NOTE: the data registers are reset along with the valids so that a reset
  // mid-job leaves no stale partial sums anywhere in the pipeline.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      node_q <= '{default: '0};
      vld_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every level samples the values its
      // children held before this edge, not ones updated in the same edge.
      node_q <= node_d;
      vld_q  <= vld_d;
    end
  end

  assign sum_data  = node_q[1];
  assign sum_valid = vld_q[L-1];

endmodule

// File: rtl/cim_column_accum.sv
// -----------------------------------------------------------------------------
// cim_column_accum
// Column reduction stage behind the CIM cell array. Reduces each column vector
// with cim_adder_tree, accumulates max(acc_len,1) valid tree sums into a
// saturating partial sum and offers it on a valid/ready port.
//   clk, rst_n : clock, asynchronous active-high reset (name kept for
//                consistency with the rest of the codebase)
//   start      : one-cycle pulse starting a job; accepted in IDLE, or in OUT
//                together with the result handshake
//   acc_len    : tree sums per job, sampled on an accepted start (0 means 1)
//   bus        : products/valids in, out_data/out_valid/out_ready result port
//   busy       : state is not IDLE
//   ovf        : sticky, a job saturated; cleared by an accepted start
//   drop       : sticky, a tree sum arrived with no job collecting it;
//                cleared by an accepted start
// -----------------------------------------------------------------------------
module cim_column_accum
  import cim_pkg::*;
#(
  parameter int NUM_ROWS   = 8,
  parameter int PROD_WIDTH = PROD_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] acc_len,
  cim_column_accum_if.slave    bus,
  output logic                 busy,
  output logic                 ovf,
  output logic                 drop
);

  localparam int SUM_W = PROD_WIDTH + tree_depth(NUM_ROWS);
  localparam int EXT_W = ACC_WIDTH + 1;

  logic [SUM_W-1:0] tree_sum;
  logic             tree_valid;

  cim_adder_tree #(
    .NUM_ROWS  (NUM_ROWS),
    .PROD_WIDTH(PROD_WIDTH)
  ) u_tree (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (bus.in_data),
    .in_valid (bus.in_valid),
    .sum_data (tree_sum),
    .sum_valid(tree_valid)
  );

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic                 out_valid_q, out_valid_d;
  logic                 ovf_q, ovf_d;
  logic                 drop_q, drop_d;
  logic                 handshake;
  logic                 load;
  logic [EXT_W-1:0]     acc_ext;
  logic [ACC_WIDTH-1:0] acc_sat;

  // One spare bit catches the carry out; any carry clamps to all ones.
  assign acc_ext   = {1'b0, acc_q} + EXT_W'(tree_sum);
  assign acc_sat   = acc_ext[ACC_WIDTH] ? '1 : acc_ext[ACC_WIDTH-1:0];
  assign handshake = out_valid_q && bus.out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; load marks an accepted start.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (tree_valid && rem_q == CNT_WIDTH'(1)) state_d = OUT;
      end
      OUT: begin
        if (handshake) begin
          if (start) begin
            load    = 1'b1;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through
    // the block leaves one unassigned and infers a latch.
    acc_d       = acc_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    drop_d      = drop_q;

    if (state_q == ACCUM && tree_valid) begin
      acc_d = acc_sat;
      rem_d = rem_q - CNT_WIDTH'(1);
      if (acc_ext[ACC_WIDTH]) ovf_d = 1'b1;
      if (rem_q == CNT_WIDTH'(1)) begin
        out_data_d  = acc_sat;
        out_valid_d = 1'b1;
      end
    end

    if (handshake) out_valid_d = 1'b0;

    if (load) begin
      acc_d  = '0;
      rem_d  = (acc_len == '0) ? CNT_WIDTH'(1) : acc_len;
      ovf_d  = 1'b0;
      drop_d = 1'b0;
    end

    // Loads only happen outside ACCUM, so this also covers a sum landing in
    // the start cycle; placed after the load so it wins over the clear.
    if (tree_valid && state_q != ACCUM) drop_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc_q       <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
    end
  end

  // Outputs, all straight from registers.
  always_comb begin
    busy          = (state_q != IDLE);
    bus.out_data  = out_data_q;
    bus.out_valid = out_valid_q;
    ovf           = ovf_q;
    drop          = drop_q;
  end

endmodule

// File: tb/tb_cim_column_accum.sv
// -----------------------------------------------------------------------------
// tb_cim_column_accum
// Bench for cim_column_accum. A job-level model (vector sums delayed by the
// tree depth, saturating accumulate, sticky flags) is compared against the
// 8-row DUT every cycle; directed jobs also pin literal results. A second
// 4-row, 18-bit instance covers saturation.
// -----------------------------------------------------------------------------
module tb_cim_column_accum;

  localparam int NR   = 8;
  localparam int PW   = 16;
  localparam int AW   = 32;
  localparam int CW   = 8;
  localparam int L    = 3;
  localparam int NR_S = 4;
  localparam int AW_S = 18;
  localparam longint MAX = (longint'(1) << AW) - 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, start_s = 1'b0;
  logic [CW-1:0] acc_len = '0, acc_len_s = '0;
  logic          busy, ovf, drop, busy_s, ovf_s, drop_s;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int lat;

  always #5 clk = ~clk;

  cim_column_accum_if #(.NUM_ROWS(NR),   .PROD_WIDTH(PW), .ACC_WIDTH(AW))   bus   ();
  cim_column_accum_if #(.NUM_ROWS(NR_S), .PROD_WIDTH(PW), .ACC_WIDTH(AW_S)) bus_s ();

  cim_column_accum #(.NUM_ROWS(NR), .PROD_WIDTH(PW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_len(acc_len),
    .bus(bus), .busy(busy), .ovf(ovf), .drop(drop)
  );

  cim_column_accum #(.NUM_ROWS(NR_S), .PROD_WIDTH(PW), .ACC_WIDTH(AW_S), .CNT_WIDTH(CW)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .acc_len(acc_len_s),
    .bus(bus_s), .busy(busy_s), .ovf(ovf_s), .drop(drop_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- job-level model of the 8-row DUT ----------------
  typedef struct {bit v; longint s;} tsum_t;
  tsum_t  m_pipe[$];
  tsum_t  m_arr;
  bit     m_busy, m_oval, m_ovf, m_drop, m_hs, m_ld, m_coll;
  longint m_acc, m_rem, m_res;

  function automatic longint vec_sum(input logic [NR*PW-1:0] d, input logic [NR-1:0] m);
    longint s = 0;
    for (int i = 0; i < NR; i++) if (m[i]) s += longint'(d[i*PW +: PW]);
    return s;
  endfunction

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_pipe.delete();
      for (int i = 0; i < L; i++) m_pipe.push_back('{v: 1'b0, s: 0});
      m_busy = 0; m_oval = 0; m_ovf = 0; m_drop = 0;
      m_acc = 0; m_rem = 0; m_res = 0;
    end else begin
      // A vector sampled now reaches the accumulator L edges later.
      m_arr = m_pipe.pop_front();
      m_pipe.push_back('{v: |bus.in_valid, s: vec_sum(bus.in_data, bus.in_valid)});
      m_coll = m_busy && !m_oval;
      m_hs   = m_oval && bus.out_ready;
      m_ld   = start && (!m_busy || m_hs);
      if (m_coll && m_arr.v) begin
        m_acc = m_acc + m_arr.s;
        if (m_acc > MAX) begin m_acc = MAX; m_ovf = 1; end
        m_rem--;
        if (m_rem == 0) begin m_res = m_acc; m_oval = 1; end
      end
      if (m_hs) begin m_oval = 0; m_busy = 0; end
      if (m_ld) begin
        m_busy = 1; m_acc = 0; m_ovf = 0; m_drop = 0;
        m_rem  = (acc_len == 0) ? 1 : longint'(acc_len);
      end
      if (m_arr.v && !m_coll) m_drop = 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", busy, m_busy);
      check("cyc_out_valid", bus.out_valid, m_oval);
      check("cyc_ovf", ovf, m_ovf);
      check("cyc_drop", drop, m_drop);
      if (m_oval || rst_n) check("cyc_out_data", bus.out_data, rst_n ? 64'd0 : m_res);
    end
  end

  // ---------------- stimulus ----------------
  logic [NR*PW-1:0] vq[$];
  logic [NR-1:0]    mq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR*PW-1:0] ramp(input int first, input int inc);
    logic [NR*PW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*PW +: PW] = PW'(first + i * inc);
    return r;
  endfunction

  // Starts a job with the vectors in vq/mq on consecutive cycles and waits for
  // out_valid; lat = cycles from the start cycle to the first out_valid cycle.
  task automatic run_job(input logic [CW-1:0] len, output int lat_o);
    start   = 1'b1;
    acc_len = len;
    foreach (vq[i]) begin
      bus.in_data  = vq[i];
      bus.in_valid = mq[i];
      tick();
      if (i == 0) begin
        start         = 1'b0;
        bus.out_ready = 1'b0;
        check("busy_after_start", busy, 1);
        check("no_valid_after_start", bus.out_valid, 0);
      end
    end
    bus.in_data  = '0;
    bus.in_valid = '0;
    lat_o = vq.size();
    while (!bus.out_valid && lat_o < 50) begin
      tick();
      lat_o++;
    end
    check("job_out_valid", bus.out_valid, 1);
    vq.delete();
    mq.delete();
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_data = '0;   bus.in_valid = '0;   bus.out_ready = 1'b0;
    bus_s.in_data = '0; bus_s.in_valid = '0; bus_s.out_ready = 1'b0;
    #1 rst_n = 1'b1;
    #1 cmp_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf_drop", {ovf, drop, ovf_s, drop_s, busy_s}, 0);

    // Basic sum: products 1..8 all valid.
    vq.push_back(ramp(1, 1)); mq.push_back(8'hFF);
    run_job(8'd1, lat);
    check("basic_latency", lat, 4);
    check("basic_data", bus.out_data, 36);
    check("basic_busy_in_out", busy, 1);
    accept();
    check("basic_idle_busy", busy, 0);
    check("basic_idle_valid", bus.out_valid, 0);

    // acc_len = 0 behaves as 1.
    vq.push_back(ramp(1, 1)); mq.push_back(8'hFF);
    run_job(8'd0, lat);
    check("len0_latency", lat, 4);
    check("len0_data", bus.out_data, 36);
    accept();

    // Lane masking: lanes 4..7 carry 0xFFFF but are invalid.
    vq.push_back({{4{16'hFFFF}}, {4{16'd100}}}); mq.push_back(8'h0F);
    run_job(8'd1, lat);
    check("mask_data", bus.out_data, 400);
    accept();

    // Three vectors summing to 10, 20, 30 (upper lanes masked junk).
    vq.push_back(ramp(1, 1)); mq.push_back(8'h0F);
    vq.push_back(ramp(2, 2)); mq.push_back(8'h0F);
    vq.push_back(ramp(3, 3)); mq.push_back(8'h0F);
    run_job(8'd3, lat);
    check("multi_latency", lat, 6);
    check("multi_data", bus.out_data, 60);
    accept();

    // Backpressure: a vector arriving while the result waits is dropped.
    vq.push_back(ramp(1, 1)); mq.push_back(8'hFF);
    run_job(8'd1, lat);
    bus.in_data = ramp(5, 1); bus.in_valid = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.in_data = '0; bus.in_valid = '0;
      check("hold_data", bus.out_data, 36);
      check("hold_valid", bus.out_valid, 1);
    end
    check("drop_set", drop, 1);
    accept();
    check("drop_sticky", drop, 1);
    vq.push_back(ramp(2, 2)); mq.push_back(8'hFF);
    run_job(8'd1, lat);
    check("drop_cleared", drop, 0);
    check("after_drop_data", bus.out_data, 72);
    accept();

    // Saturation on the 18-bit instance: 4 x 262140 clamps to 0x3FFFF.
    start_s = 1'b1; acc_len_s = 8'd4;
    bus_s.in_data = {4{16'hFFFF}}; bus_s.in_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      tick();
      start_s = 1'b0;
    end
    bus_s.in_data = '0; bus_s.in_valid = '0;
    lat = 4;
    while (!bus_s.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("sat_latency", lat, 6);
    check("sat_data", bus_s.out_data, 18'h3FFFF);
    check("sat_ovf", ovf_s, 1);
    check("sat_drop", drop_s, 0);
    bus_s.out_ready = 1'b1;
    tick();
    bus_s.out_ready = 1'b0;
    check("sat_idle", {busy_s, bus_s.out_valid}, 0);

    // Reset mid-ACCUM clears everything immediately.
    start = 1'b1; acc_len = 8'd3;
    bus.in_data = ramp(1, 1); bus.in_valid = 8'hFF;
    tick();
    start = 1'b0; bus.in_data = '0; bus.in_valid = '0;
    tick();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_data", bus.out_data, 0);
    check("mid_rst_flags", {bus.out_valid, ovf, drop, ovf_s}, 0);
    tick();
    rst_n = 1'b0;
    tick();

    // Back-to-back: new start in the handshake cycle, no IDLE in between.
    vq.push_back(ramp(1, 1)); mq.push_back(8'hFF);
    run_job(8'd1, lat);
    check("b2b_first_data", bus.out_data, 36);
    bus.out_ready = 1'b1;
    vq.push_back(ramp(1, 1)); mq.push_back(8'h0F);
    vq.push_back(ramp(2, 2)); mq.push_back(8'h0F);
    run_job(8'd2, lat);
    check("b2b_latency", lat, 5);
    check("b2b_data", bus.out_data, 30);
    accept();
    check("b2b_idle", busy, 0);

    repeat (3) tick();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cim_column_accum.md
# cim_column_accum

Column reduction stage directly downstream of the CIM cell array. It takes the registered 16-bit products and per-cell valid flags of one column of NUM_ROWS cells, reduces them through a pipelined unsigned adder tree, and accumulates ACC_LEN successive tree sums into one saturating partial sum. The partial sum is handed to the next stage over a valid/ready port.

## Interface
- NUM_ROWS, 8: cells per column; power of two, at least 2.
- PROD_WIDTH, 16: product width per cell.
- ACC_WIDTH, 32: accumulator and result width; must be at least PROD_WIDTH+log2(NUM_ROWS).
- CNT_WIDTH, 8: width of the accumulation-length field.
- clk  in  1  sole clock; everything is on the rising edge.
- rst_n  in  1  asynchronous, active-high reset (asserted = 1). The name is kept for codebase consistency.
- start  in  1  one-cycle pulse that begins an accumulation.
- acc_len  in  CNT_WIDTH  number of tree sums to accumulate; sampled on start. A value of 0 is treated as 1.
- in_data  in  NUM_ROWS*PROD_WIDTH  cell products; lane i is bits [i*PROD_WIDTH +: PROD_WIDTH].
- in_valid  in  NUM_ROWS  per-lane valid from each cell.
- out_data  out  ACC_WIDTH  final partial sum.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high while state is not IDLE.
- ovf  out  1  sticky saturation flag; cleared by an accepted start.
- drop  out  1  sticky flag set when a tree sum is discarded; cleared by an accepted start.

## Operation
- **Lane masking**: a lane whose in_valid bit is 0 contributes 0. The vector is valid when the OR of in_valid is 1.
- **Adder tree**: unsigned, with log2(NUM_ROWS)=L registered levels. Each level widens by 1 bit, so the tree sum is PROD_WIDTH+L bits. A valid bit travels with each level.
- **Tree-sum valid rule**: the pipeline is free-running with no stall. Upstream has no ready signal, so the tree never backpressures.
- **State machine**: IDLE, ACCUM, OUT.
- **IDLE**:
  - start moves to ACCUM.
  - On that move: acc is cleared, remaining is loaded with max(acc_len,1), and ovf and drop are cleared.
- **ACCUM**:
  - On each valid tree sum: acc is updated to acc + sum, saturating at 2^ACC_WIDTH-1 and setting ovf if it saturates. remaining is decremented.
  - When a valid sum arrives with remaining==1: out_data is loaded with the final acc, out_valid is set, and the state moves to OUT.
- **OUT**:
  - out_data and out_valid are held until out_valid&&out_ready.
  - On the handshake: if start is high in the same cycle, go straight to ACCUM with a fresh load. Otherwise go to IDLE.
- **start outside the accepted cases**: start in ACCUM, or in OUT without a handshake, is ignored.
- **Discarded sums**: a valid tree sum reaching the accumulator in IDLE or OUT, or in the same cycle start is accepted, is discarded and sets drop. Inputs presented in the start cycle or later are counted.
- **Reset**: assertion mid-operation aborts immediately.
  - State goes to IDLE; pipeline data and valid registers, acc and remaining clear to 0.
  - Output reset values: out_data=0, out_valid=0, busy=0, ovf=0, drop=0.

## Timing
- A vector sampled at edge t produces a valid tree sum in cycle t+L. The sum is accumulated at the end of cycle t+L.
- For the last vector, out_valid is high from cycle t+L+1. Latency from the last input to out_valid is L+1 cycles (4 for NUM_ROWS=8).
- One vector can be accepted every cycle. A job of N vectors presented back-to-back produces out_valid N+L cycles after start.
- busy goes high the cycle after start is accepted. It falls the cycle after the handshake unless a back-to-back start was accepted.
- out_valid never depends combinationally on out_ready.

## Structure
- **Shared package cim_pkg**:
  - Holds the state enum (IDLE, ACCUM, OUT).
  - Holds the default width constants PROD_WIDTH_DEF=16, ACC_WIDTH_DEF=32 and the tree-depth function clog2-based.
- **Sub-module cim_adder_tree**:
  - Parameterised by NUM_ROWS and PROD_WIDTH.
  - Does the masking, the registered reduction levels and the valid pipeline.
  - Instantiated once.
- The FSM, accumulator and output register live in cim_column_accum.

## Test plan
- **Basic sum**: reset, then start with acc_len=1. Present all 8 lanes valid with products 1..8 → out_valid is high 4 cycles later with out_data=36, and busy is 1 during the job.
- **Lane masking**: lanes 0–3 valid =100 each, lanes 4–7 invalid =0xFFFF → out_data=400.
- **Multi-vector accumulation**: acc_len=3, vectors summing to 10, 20 and 30 on consecutive cycles → out_data=60, out_valid at start+3+3.
- **Backpressure and drops**: hold out_ready=0 for 5 cycles while a valid vector arrives in OUT → out_data stays stable, drop=1. A following start clears drop.
- **Saturation**: ACC_WIDTH=18 with acc_len=4, every lane 0xFFFF → out_data=0x3FFFF and ovf=1.
- **Reset and back-to-back**:
  - Assert rst_n mid-ACCUM → all outputs 0 and state IDLE within the same cycle.
  - Then run start together with an out_ready handshake → the second job runs with no IDLE cycle and its result is correct.
